sap_control_sequencer: RTL and testbench

Microcoded control sequencer for the 8-bit accumulator computer. It steps through fetch and execute T-states and decodes the opcode from the instruction register. It drives every bus and load enable in the datapath, including the ALU `sub_bAdd` select. It owns the carry/zero flag register that conditional jumps read. It sits between the instruction register and all datapath blocks (PC, MAR, RAM, A, B, ALU, output register).

---
 rtl/sap_control_sequencer.sv | 132 +++++++++++++
 tb/tb_sap_control_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// Control sequencer for the 8-bit accumulator computer: T-state FSM, opcode decode
// into datapath bus/load enables, and the carry/zero flag register read by JC/JZ.
module sap_control_sequencer #(
  parameter int DataBits = 8,
  parameter int OpBits   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DataBits-1:0] instr,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ram_load,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                sub_bAdd,
  output logic                out_load,
  output logic                carry_q,
  output logic                zero_q,
  output logic [2:0]          tstate,
  output logic                halted
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, HALT = 3'd7
  } state_t;

  localparam logic [OpBits-1:0] OP_LDA = OpBits'(4'h1);
  localparam logic [OpBits-1:0] OP_ADD = OpBits'(4'h2);
  localparam logic [OpBits-1:0] OP_SUB = OpBits'(4'h3);
  localparam logic [OpBits-1:0] OP_STA = OpBits'(4'h4);
  localparam logic [OpBits-1:0] OP_LDI = OpBits'(4'h5);
  localparam logic [OpBits-1:0] OP_JMP = OpBits'(4'h6);
  localparam logic [OpBits-1:0] OP_JC  = OpBits'(4'h7);
  localparam logic [OpBits-1:0] OP_JZ  = OpBits'(4'h8);
  localparam logic [OpBits-1:0] OP_OUT = OpBits'(4'hE);
  localparam logic [OpBits-1:0] OP_HLT = OpBits'(4'hF);

  state_t              state;
  logic [OpBits-1:0]   op;
  logic                flags_load;

  assign op = instr[DataBits-1 -: OpBits];

  function automatic state_t nxt(input state_t s, input logic [OpBits-1:0] o);
    case (s)
      T0:      return T1;
      T1:      return T2;
      T2: begin
        if (o == OP_HLT) return HALT;
        if (o == OP_LDA || o == OP_ADD || o == OP_SUB || o == OP_STA) return T3;
        return T0;
      end
      T3:      return (o == OP_ADD || o == OP_SUB) ? T4 : T0;
      T4:      return T0;
      default: return HALT;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= T0;
      tstate  <= 3'd0;
      halted  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state  <= nxt(state, op);
      tstate <= nxt(state, op);
      halted <= (nxt(state, op) == HALT);
      if (flags_load) begin
        carry_q <= carry_flag;
        zero_q  <= zero_flag;
      end
    end
  end

  // Controls decode straight from state so reset kills an in-flight write at once.
  always_comb begin
    pc_out = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; mar_load = 1'b0;
    ram_out = 1'b0; ram_load = 1'b0; ir_load = 1'b0; ir_out = 1'b0;
    a_load = 1'b0; a_out = 1'b0; b_load = 1'b0; alu_out = 1'b0;
    sub_bAdd = 1'b0; out_load = 1'b0; flags_load = 1'b0;
    if (!rst) begin
      case (state)
        T0: begin pc_out = 1'b1; mar_load = 1'b1; end
        T1: begin ram_out = 1'b1; ir_load = 1'b1; pc_inc = 1'b1; end
        T2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_out = 1'b1; mar_load = 1'b1; end
            OP_LDI: begin ir_out = 1'b1; a_load = 1'b1; end
            OP_JMP: begin ir_out = 1'b1; pc_load = 1'b1; end
            OP_JC:  begin ir_out = 1'b1; pc_load = carry_q; end
            OP_JZ:  begin ir_out = 1'b1; pc_load = zero_q; end
            OP_OUT: begin a_out = 1'b1; out_load = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (op)
            OP_LDA: begin ram_out = 1'b1; a_load = 1'b1; end
            OP_ADD, OP_SUB: begin
              ram_out  = 1'b1;
              b_load   = 1'b1;
              sub_bAdd = (op == OP_SUB);
            end
            OP_STA: begin a_out = 1'b1; ram_load = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            alu_out    = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            sub_bAdd   = (op == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed + randomized bench for sap_control_sequencer against a per-instruction
// micro-step table model with its own flag register.
module tb_sap_control_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       carry_flag, zero_flag;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, sub_bAdd, out_load;
  logic       carry_q, zero_q, halted;
  logic [2:0] tstate;
  logic [13:0] ctrl;

  int ntests = 0;
  int nfail  = 0;
  bit mc, mz;

  localparam logic [13:0] PCO = 14'h2000, PCI = 14'h1000, PCL = 14'h0800, MAR = 14'h0400;
  localparam logic [13:0] RMO = 14'h0200, RML = 14'h0100, IRL = 14'h0080, IRO = 14'h0040;
  localparam logic [13:0] AL  = 14'h0020, AO  = 14'h0010, BL  = 14'h0008, ALU = 14'h0004;
  localparam logic [13:0] SUB = 14'h0002, OUTL = 14'h0001;

  sap_control_sequencer #(.DataBits(8), .OpBits(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_load(ram_load), .ir_load(ir_load), .ir_out(ir_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .sub_bAdd(sub_bAdd), .out_load(out_load), .carry_q(carry_q), .zero_q(zero_q),
    .tstate(tstate), .halted(halted)
  );

  assign ctrl = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out,
                 a_load, a_out, b_load, alu_out, sub_bAdd, out_load};

  always #5 clk = ~clk;

  function automatic int ilen(input logic [3:0] op);
    if (op == 4'h1 || op == 4'h4) return 4;
    if (op == 4'h2 || op == 4'h3) return 5;
    return 3;
  endfunction

  // Micro-step table straight from the instruction set description.
  function automatic logic [13:0] ustep(input logic [3:0] op, input int k, input bit c, input bit z);
    if (k == 0) return PCO | MAR;
    if (k == 1) return RMO | IRL | PCI;
    case (op)
      4'h1: return (k == 2) ? (IRO | MAR) : (RMO | AL);
      4'h2: return (k == 2) ? (IRO | MAR) : (k == 3) ? (RMO | BL) : (ALU | AL);
      4'h3: return (k == 2) ? (IRO | MAR) : (k == 3) ? (RMO | BL | SUB) : (ALU | AL | SUB);
      4'h4: return (k == 2) ? (IRO | MAR) : (AO | RML);
      4'h5: return IRO | AL;
      4'h6: return IRO | PCL;
      4'h7: return c ? (IRO | PCL) : IRO;
      4'h8: return z ? (IRO | PCL) : IRO;
      4'hE: return AO | OUTL;
      default: return 14'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".carry_q"}, 32'(carry_q), 32'(mc));
    chk({tag, ".zero_q"},  32'(zero_q),  32'(mz));
  endtask

  // Runs one instruction; cf/zf are the ALU flags presented in T4.
  // abort_at >= 0 pulses reset during that step after its checks.
  task automatic run_instr(input logic [7:0] ins, input bit cf, input bit zf, input int abort_at);
    logic [3:0] op;
    op = ins[7:4];
    for (int k = 0; k < ilen(op); k++) begin
      instr      = (k < 2) ? 8'($urandom) : ins;
      carry_flag = (k == 4) ? cf : 1'($urandom);
      zero_flag  = (k == 4) ? zf : 1'($urandom);
      #1;
      chk($sformatf("op%0h.t%0d.tstate", op, k), 32'(tstate), 32'(k));
      chk($sformatf("op%0h.t%0d.ctrl", op, k), 32'(ctrl), 32'(ustep(op, k, mc, mz)));
      chk($sformatf("op%0h.t%0d.halted", op, k), 32'(halted), 32'd0);
      chk_flags($sformatf("op%0h.t%0d", op, k));
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        mc = 1'b0; mz = 1'b0;
        chk("abort.ram_load", 32'(ram_load), 32'd0);
        chk("abort.ctrl", 32'(ctrl), 32'd0);
        chk("abort.tstate", 32'(tstate), 32'd0);
        chk_flags("abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(posedge clk);
      if (k == 4) begin mc = cf; mz = zf; end
      #1;
    end
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      instr = 8'($urandom); carry_flag = 1'($urandom); zero_flag = 1'($urandom);
      #1;
      chk("halt.tstate", 32'(tstate), 32'd7);
      chk("halt.halted", 32'(halted), 32'd1);
      chk("halt.ctrl", 32'(ctrl), 32'd0);
      chk_flags("halt");
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rst = 1'b1;
    #1;
    mc = 1'b0; mz = 1'b0;
    chk("rst.ctrl", 32'(ctrl), 32'd0);
    chk("rst.tstate", 32'(tstate), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk_flags("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = 8'h00; carry_flag = 1'b1; zero_flag = 1'b1;
    mc = 1'b0; mz = 1'b0;
    #1;
    chk("init.ctrl", 32'(ctrl), 32'd0);
    chk("init.tstate", 32'(tstate), 32'd0);
    chk("init.halted", 32'(halted), 32'd0);
    chk_flags("init");
    @(negedge clk);
    rst = 1'b0;

    run_instr(8'h00, 1'b0, 1'b0, -1);   // NOP
    run_instr(8'h55, 1'b0, 1'b0, -1);   // LDI 5
    run_instr(8'h2A, 1'b1, 1'b0, -1);   // ADD, carry set
    run_instr(8'h73, 1'b0, 1'b0, -1);   // JC taken
    run_instr(8'h2B, 1'b0, 1'b0, -1);   // ADD, carry clear
    run_instr(8'h73, 1'b0, 1'b0, -1);   // JC not taken
    run_instr(8'h3F, 1'b1, 1'b1, -1);   // SUB, zero set
    run_instr(8'h81, 1'b0, 1'b0, -1);   // JZ taken
    run_instr(8'h14, 1'b0, 1'b0, -1);   // LDA
    run_instr(8'h4C, 1'b0, 1'b0, -1);   // STA
    run_instr(8'h6E, 1'b0, 1'b0, -1);   // JMP
    run_instr(8'hE0, 1'b0, 1'b0, -1);   // OUT
    run_instr(8'hB7, 1'b0, 1'b0, -1);   // unassigned opcode
    run_instr(8'hF0, 1'b0, 1'b0, -1);   // HLT
    halt_cycles(22);
    reset_seq();
    run_instr(8'h00, 1'b0, 1'b0, -1);
    run_instr(8'h4A, 1'b0, 1'b0, 3);    // STA aborted by reset in T3
    run_instr(8'h00, 1'b0, 1'b0, -1);

    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 59) begin
        run_instr(8'hF0, 1'b0, 1'b0, -1);
        halt_cycles(3);
        reset_seq();
      end else begin
        run_instr({4'($urandom_range(0, 14)), 4'($urandom)}, 1'($urandom), 1'($urandom), -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
